// File: rtl/tic_tac_toe_pkg.sv
// Shared cell/winner codes, line and preference tables, and FSM states
// for the tic-tac-toe computer opponent.
package tic_tac_toe_pkg;

   typedef logic [1:0] cell_t;
   typedef logic [1:0] win_t;
   typedef logic [3:0] cell_idx_t;

   localparam cell_t CELL_EMPTY  = 2'b00;
   localparam cell_t CELL_PLAYER = 2'b01;
   localparam cell_t CELL_PC     = 2'b10;

   localparam win_t WIN_NONE   = 2'b00;
   localparam win_t WIN_PLAYER = 2'b01;
   localparam win_t WIN_PC     = 2'b10;

   localparam int unsigned NUM_CELLS = 9;
   localparam int unsigned NUM_LINES = 8;

   // Rows, columns, then the two diagonals; scan order sets the tie-break.
   localparam cell_idx_t LINE_TBL [NUM_LINES][3] = '{
      '{4'd0, 4'd1, 4'd2}, '{4'd3, 4'd4, 4'd5}, '{4'd6, 4'd7, 4'd8},
      '{4'd0, 4'd3, 4'd6}, '{4'd1, 4'd4, 4'd7}, '{4'd2, 4'd5, 4'd8},
      '{4'd0, 4'd4, 4'd8}, '{4'd2, 4'd4, 4'd6}
   };

   // Centre, corners, then edges.
   localparam cell_idx_t PREF_TBL [NUM_CELLS] = '{
      4'd4, 4'd0, 4'd2, 4'd6, 4'd8, 4'd1, 4'd3, 4'd5, 4'd7
   };

   typedef enum logic [2:0] {
      IDLE, CHECK, SCAN_WIN, SCAN_BLOCK, PREFER, ISSUE, NOMOVE
   } state_e;

endpackage

// File: rtl/tic_tac_toe_ai_player_if.sv
// Board/move interface between the game core (master) and the computer opponent (slave).
interface tic_tac_toe_ai_player_if
   import tic_tac_toe_pkg::*;
#(
   parameter int unsigned POS_W = 4
) ();

   logic             start;
   cell_t            pos1, pos2, pos3, pos4, pos5, pos6, pos7, pos8, pos9;
   win_t             who;
   logic [POS_W-1:0] computer_position;
   logic             pc;
   logic             busy;
   logic             no_move;

   modport master (
      output start, pos1, pos2, pos3, pos4, pos5, pos6, pos7, pos8, pos9, who,
      input  computer_position, pc, busy, no_move
   );

   modport slave (
      input  start, pos1, pos2, pos3, pos4, pos5, pos6, pos7, pos8, pos9, who,
      output computer_position, pc, busy, no_move
   );

endinterface

// File: rtl/tic_tac_toe_line_eval.sv
// Combinational line check: two cells carry the target mark and the third is empty.
module tic_tac_toe_line_eval
   import tic_tac_toe_pkg::*;
(
   input  cell_t       a_i,
   input  cell_t       b_i,
   input  cell_t       c_i,
   input  cell_t       mark_i,
   output logic        hit_c_o,
   output logic [1:0]  off_c_o
);

   logic [1:0] n_mark;
   logic [1:0] n_empty;

   always_comb begin
      n_mark  = 2'(a_i == mark_i) + 2'(b_i == mark_i) + 2'(c_i == mark_i);
      n_empty = 2'(a_i == CELL_EMPTY) + 2'(b_i == CELL_EMPTY) + 2'(c_i == CELL_EMPTY);
      hit_c_o = (n_mark == 2'd2) && (n_empty == 2'd1);
      if (a_i == CELL_EMPTY)      off_c_o = 2'd0;
      else if (b_i == CELL_EMPTY) off_c_o = 2'd1;
      else                        off_c_o = 2'd2;
   end

endmodule

// File: rtl/tic_tac_toe_ai_player.sv
// Computer opponent: snapshots the board on start, scans win lines, block lines,
// then a fixed preference list, and commits one move with a single-cycle pc pulse.
module tic_tac_toe_ai_player
   import tic_tac_toe_pkg::*;
#(
   parameter int unsigned POS_W        = 4,
   parameter bit          ENABLE_BLOCK = 1'b1
) (
   input  logic                   clock_i,
   input  logic                   reset_i,
   tic_tac_toe_ai_player_if.slave game
);

   state_e    state_q;
   cell_idx_t idx_q;
   cell_t     board_q [NUM_CELLS];
   cell_idx_t pos_q;
   logic      pc_q;
   logic      busy_q;
   logic      no_move_q;

   cell_t     pos_in [NUM_CELLS];
   cell_t     mark_d;
   cell_t     line_a, line_b, line_c;
   logic      hit_d;
   logic [1:0] off_d;
   cell_idx_t line_cell_d;
   cell_idx_t pref_cell_d;
   logic      pref_free_d;

   always_comb begin
      pos_in = '{game.pos1, game.pos2, game.pos3, game.pos4, game.pos5,
                 game.pos6, game.pos7, game.pos8, game.pos9};
   end

   // One evaluator serves both scans; only the target mark changes.
   always_comb begin
      mark_d      = (state_q == SCAN_BLOCK) ? CELL_PLAYER : CELL_PC;
      line_a      = board_q[LINE_TBL[idx_q[2:0]][0]];
      line_b      = board_q[LINE_TBL[idx_q[2:0]][1]];
      line_c      = board_q[LINE_TBL[idx_q[2:0]][2]];
      line_cell_d = LINE_TBL[idx_q[2:0]][off_d];
      pref_cell_d = PREF_TBL[idx_q];
      pref_free_d = (board_q[pref_cell_d] == CELL_EMPTY);
   end

   tic_tac_toe_line_eval u_line_eval (
      .a_i     (line_a),
      .b_i     (line_b),
      .c_i     (line_c),
      .mark_i  (mark_d),
      .hit_c_o (hit_d),
      .off_c_o (off_d)
   );

   // A finished game is resolved at acceptance so no_move lands one cycle after start.
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         state_q   <= IDLE;
         idx_q     <= '0;
         pos_q     <= '0;
         pc_q      <= 1'b0;
         busy_q    <= 1'b0;
         no_move_q <= 1'b0;
         for (int i = 0; i < NUM_CELLS; i++) board_q[i] <= CELL_EMPTY;
      end else begin
         pc_q      <= 1'b0;
         no_move_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (game.start) begin
                  for (int i = 0; i < NUM_CELLS; i++) board_q[i] <= pos_in[i];
                  idx_q  <= '0;
                  busy_q <= 1'b1;
                  if (game.who != WIN_NONE) begin
                     no_move_q <= 1'b1;
                     state_q   <= NOMOVE;
                  end else begin
                     state_q <= CHECK;
                  end
               end
            end
            CHECK, SCAN_WIN: begin
               if (hit_d) begin
                  pos_q   <= line_cell_d;
                  pc_q    <= 1'b1;
                  state_q <= ISSUE;
               end else if (idx_q == 4'd7) begin
                  idx_q   <= '0;
                  state_q <= ENABLE_BLOCK ? SCAN_BLOCK : PREFER;
               end else begin
                  idx_q   <= idx_q + 4'd1;
                  state_q <= SCAN_WIN;
               end
            end
            SCAN_BLOCK: begin
               if (hit_d) begin
                  pos_q   <= line_cell_d;
                  pc_q    <= 1'b1;
                  state_q <= ISSUE;
               end else if (idx_q == 4'd7) begin
                  idx_q   <= '0;
                  state_q <= PREFER;
               end else begin
                  idx_q <= idx_q + 4'd1;
               end
            end
            PREFER: begin
               if (pref_free_d) begin
                  pos_q   <= pref_cell_d;
                  pc_q    <= 1'b1;
                  state_q <= ISSUE;
               end else if (idx_q == 4'd8) begin
                  no_move_q <= 1'b1;
                  state_q   <= NOMOVE;
               end else begin
                  idx_q <= idx_q + 4'd1;
               end
            end
            ISSUE, NOMOVE: begin
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign game.computer_position = POS_W'(pos_q);
   assign game.pc                = pc_q;
   assign game.busy              = busy_q;
   assign game.no_move           = no_move_q;

endmodule
